// File: rtl/fetch_controller_if.sv
// Fetch-stage bundle: PC update, imem request handshake, decode/redirect controls.
// The controller uses the master modport; the PC/imem/decode side uses slave.
interface fetch_controller_if;
  logic [31:0] curr_addr;
  logic [31:0] next_addr;
  logic        stall_fetch_stg;
  logic        imem_req;
  logic        imem_rdy;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        flush_if;
  logic        fetch_err;
  logic        misalign_trap;

  modport master (
    input  curr_addr, imem_rdy, hazard_stall, redirect_valid, redirect_target,
    output next_addr, stall_fetch_stg, imem_req, if_valid, flush_if, fetch_err, misalign_trap
  );

  modport slave (
    output curr_addr, imem_rdy, hazard_stall, redirect_valid, redirect_target,
    input  next_addr, stall_fetch_stg, imem_req, if_valid, flush_if, fetch_err, misalign_trap
  );
endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencer: one PC decision per cycle from redirect, imem wait and decode hazard; outputs
// combinational from state. Backpressure via stall_fetch_stg; MISALIGN_TRAP_EN enables redirect trap.
module fetch_controller #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0004,
  parameter int          WAIT_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.master bus
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, ERR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(WAIT_TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] pc_inc;
  logic [31:0] redirect_addr;
  logic        misaligned;

  assign pc_inc = bus.curr_addr + 32'd4;

`ifdef MISALIGN_TRAP_EN
  assign misaligned    = |bus.redirect_target[1:0];
  assign redirect_addr = misaligned ? TRAP_VEC : bus.redirect_target;
`else
  logic unused_trap;
  assign unused_trap   = ^{bus.redirect_target[1:0], TRAP_VEC};
  assign misaligned    = 1'b0;
  assign redirect_addr = {bus.redirect_target[31:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    wait_cnt_nxt        = wait_cnt;
    bus.next_addr       = bus.curr_addr;
    bus.stall_fetch_stg = 1'b1;
    bus.imem_req        = 1'b0;
    bus.if_valid        = 1'b0;
    bus.flush_if        = 1'b0;
    bus.fetch_err       = 1'b0;
    bus.misalign_trap   = 1'b0;

    if (rst) begin
      bus.next_addr = RESET_VEC;
    end else if (state == BOOT) begin
      bus.next_addr       = RESET_VEC;
      bus.stall_fetch_stg = 1'b0;
      wait_cnt_nxt        = 8'd0;
      state_nxt           = REQ;
    end else if (bus.redirect_valid) begin
      // Dropping imem_req here cancels any pending fetch, so a same-cycle rdy is discarded.
      bus.next_addr       = redirect_addr;
      bus.stall_fetch_stg = 1'b0;
      bus.flush_if        = 1'b1;
      bus.misalign_trap   = misaligned;
      bus.fetch_err       = (state == ERR);
      wait_cnt_nxt        = 8'd0;
      state_nxt           = REQ;
    end else begin
      unique case (state)
        REQ, WAIT: begin
          bus.imem_req = 1'b1;
          if (bus.imem_rdy) begin
            bus.if_valid = 1'b1;
            wait_cnt_nxt = 8'd0;
            if (!bus.hazard_stall) begin
              bus.stall_fetch_stg = 1'b0;
              bus.next_addr       = pc_inc;
              state_nxt           = REQ;
            end else begin
              state_nxt = HOLD;
            end
          end else if (wait_cnt == TIMEOUT) begin
            wait_cnt_nxt = 8'd0;
            state_nxt    = ERR;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
            state_nxt    = WAIT;
          end
        end
        HOLD: begin
          bus.if_valid = 1'b1;
          if (!bus.hazard_stall) begin
            bus.stall_fetch_stg = 1'b0;
            bus.next_addr       = pc_inc;
            state_nxt           = REQ;
          end
        end
        ERR: begin
          bus.fetch_err = 1'b1;
        end
        default: begin
          state_nxt = BOOT;
        end
      endcase
    end
  end

  a_flush_kills_fetch: assert property (@(posedge clk) disable iff (rst)
    bus.flush_if |-> (!bus.if_valid && !bus.imem_req));
  a_trap_with_flush: assert property (@(posedge clk) disable iff (rst)
    bus.misalign_trap |-> bus.flush_if);
  a_err_no_req: assert property (@(posedge clk) disable iff (rst)
    bus.fetch_err |-> !bus.imem_req);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_fetch_controller;

  localparam logic [5:0] F_STALL = 6'b100000;
  localparam logic [5:0] F_REQ   = 6'b010000;
  localparam logic [5:0] F_VLD   = 6'b001000;
  localparam logic [5:0] F_FLUSH = 6'b000100;
  localparam logic [5:0] F_ERR   = 6'b000010;
  localparam logic [5:0] F_TRAP  = 6'b000001;

  typedef struct {
    logic [31:0] addr;
    bit          chk_addr;
    logic [5:0]  flags;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc = 32'h0000_0F00;
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_controller_if bus ();

  fetch_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Program counter register owned by the environment.
  always @(posedge clk) if (!bus.stall_fetch_stg) pc <= bus.next_addr;
  assign bus.curr_addr = pc;

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [5:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.stall_fetch_stg, bus.imem_req, bus.if_valid,
             bus.flush_if, bus.fetch_err, bus.misalign_trap};
      n_cmp++;
      if (act !== e.flags || (e.chk_addr && bus.next_addr !== e.addr)) begin
        n_err++;
        $display("FAIL %s: got next_addr=%h flags(stall,req,vld,flush,err,trap)=%b, want next_addr=%h%s flags=%b",
                 e.name, bus.next_addr, act, e.addr, e.chk_addr ? "" : "(any)", e.flags);
      end
    end
  end

  task automatic cyc(input bit r, input bit rdy, input bit hz, input bit rv,
                     input logic [31:0] tgt, input bit chk, input logic [31:0] ea,
                     input logic [5:0] ef, input string nm);
    exp_t e;
    rst                 = r;
    bus.imem_rdy        = rdy;
    bus.hazard_stall    = hz;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    e.addr = ea; e.chk_addr = chk; e.flags = ef; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.imem_rdy = 1'b0; bus.hazard_stall = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    @(posedge clk); #1;

    //  rst rdy hz rv target        chk  next_addr
    cyc(1, 1, 0, 0, 32'h0,          1, 32'h0,        F_STALL,         "reset");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h0,        6'b0,            "boot");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h4,        F_REQ | F_VLD,   "seq_4");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h8,        F_REQ | F_VLD,   "seq_8");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'hC,        F_REQ | F_VLD,   "seq_c");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h10,       F_REQ | F_VLD,   "seq_10");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,        F_STALL | F_REQ, "wait_0x10");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h14,       F_REQ | F_VLD,   "wait_done");
    cyc(0, 1, 1, 0, 32'h0,          0, 32'h0,        F_STALL | F_REQ | F_VLD, "hazard_enter");
    cyc(0, 0, 1, 0, 32'h0,          0, 32'h0,        F_STALL | F_VLD, "hazard_hold");
    cyc(0, 0, 0, 0, 32'h0,          1, 32'h18,       F_VLD,           "hazard_release");
    cyc(0, 0, 0, 0, 32'h0,          0, 32'h0,        F_STALL | F_REQ, "wait_0x18");
    cyc(0, 1, 0, 1, 32'h200,        1, 32'h200,      F_FLUSH,         "redirect_over_rdy");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h204,      F_REQ | F_VLD,   "fetch_0x200");
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, F_FLUSH,        "redirect_top");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h0,        F_REQ | F_VLD,   "pc_wrap");
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,        F_STALL | F_REQ, "timeout_wait");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,        F_STALL | F_ERR, "err_sticky");
    cyc(0, 0, 0, 1, 32'h40,         1, 32'h40,       F_FLUSH | F_ERR, "err_redirect");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h44,       F_REQ | F_VLD,   "err_cleared");
`ifdef MISALIGN_TRAP_EN
    cyc(0, 0, 0, 1, 32'h102,        1, 32'h4,        F_FLUSH | F_TRAP, "misalign_redirect");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h8,        F_REQ | F_VLD,   "after_trap");
`else
    cyc(0, 0, 0, 1, 32'h102,        1, 32'h100,      F_FLUSH,         "misalign_redirect");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h104,      F_REQ | F_VLD,   "after_misalign");
`endif
    cyc(1, 1, 0, 1, 32'h300,        1, 32'h0,        F_STALL,         "reset_over_redirect");
    cyc(0, 1, 0, 1, 32'h300,        1, 32'h0,        6'b0,            "boot_ignores_redirect");
    cyc(0, 1, 0, 0, 32'h0,          1, 32'h4,        F_REQ | F_VLD,   "after_reboot");

    @(negedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending expectations=%0d, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
